// File: rtl/bcd_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } bcd_state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

    // Smallest digit count whose decimal range covers every value of a bin_w-bit word.
    function automatic int bcd_digits_for(input int bin_w);
        logic [67:0] max_val;
        logic [67:0] pow;
        int          n;
        max_val = (68'd1 << bin_w) - 68'd1;
        pow     = 68'd10;
        n       = 1;
        while (pow <= max_val) begin
            pow = pow * 68'd10;
            n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: values of 5 and above get +3 before the shift.
module bcd_add3_digit
    import bcd_pkg::*;
(
    input  bcd_digit_t i_digit,
    output bcd_digit_t o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (double dabble, one bit per clock) with valid/ready
// on both sides and a significant-digit count for leading-zero blanking.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BIN_W-1:0]              in_bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [4*DIGITS-1:0]           out_bcd,
    output logic [$clog2(DIGITS+1)-1:0]   out_ndig,
    output logic                          busy
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int NDIG_W = $clog2(DIGITS + 1);
    localparam int CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int ACC_W  = BCD_W + BIN_W;

    if (BIN_W < 1 || BIN_W > 64) begin : g_bad_bin_w
        $error("bin2bcd_seq: BIN_W=%0d outside 1..64", BIN_W);
    end
    if (DIGITS < bcd_digits_for(BIN_W)) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS=%0d too small for BIN_W=%0d (need %0d)",
               DIGITS, BIN_W, bcd_digits_for(BIN_W));
    end

    bcd_state_e          r_state;
    logic [CNT_W-1:0]    r_count;
    logic [BIN_W-1:0]    r_bin;
    logic [BCD_W-1:0]    r_bcd;
    logic [BCD_W-1:0]    r_out_bcd;
    logic [NDIG_W-1:0]   r_out_ndig;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_busy;

    logic [BCD_W-1:0]    w_bcd_adj;
    logic [ACC_W-1:0]    w_shift;
    logic [BCD_W-1:0]    w_bcd_next;
    logic [BIN_W-1:0]    w_bin_next;
    logic [NDIG_W-1:0]   w_ndig_next;
    logic                w_last;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3_digit u_add3 (
            .i_digit (r_bcd[4*g +: 4]),
            .o_digit (w_bcd_adj[4*g +: 4])
        );

        a_digit_range : assert property (@(posedge clk) disable iff (!rst_n)
            (r_bcd[4*g +: 4] <= BCD_MAX_DIGIT) && (r_out_bcd[4*g +: 4] <= BCD_MAX_DIGIT));
    end

    // The top corrected bit never carries out: DIGITS is sized so the accumulator cannot overflow.
    assign w_shift    = {w_bcd_adj, r_bin} << 1;
    assign w_bcd_next = w_shift[ACC_W-1:BIN_W];
    assign w_bin_next = w_shift[BIN_W-1:0];
    assign w_last     = (r_count == CNT_W'(BIN_W - 1));

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_ndig_next = NDIG_W'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (w_bcd_next[4*i +: 4] != 4'd0) begin
                w_ndig_next = NDIG_W'(i + 1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_bin       <= '0;
            r_bcd       <= '0;
            r_out_bcd   <= '0;
            r_out_ndig  <= NDIG_W'(1);
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_bin      <= in_bin;
                        r_bcd      <= '0;
                        r_count    <= '0;
                        r_state    <= SHIFT;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_bcd   <= w_bcd_next;
                    r_bin   <= w_bin_next;
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        r_state     <= DONE;
                        r_out_bcd   <= w_bcd_next;
                        r_out_ndig  <= w_ndig_next;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_bcd   = r_out_bcd;
    assign out_ndig  = r_out_ndig;
    assign busy      = r_busy;

endmodule
